// File: rtl/stall_pkg.sv
// Shared types and default sizes for the clocked stall element.
//   in_state_t  : upstream handshake FSM states
//   out_state_t : downstream handshake FSM states
//   STALL_DEPTH_DEF / STALL_DATA_W_DEF : default FIFO depth and token width
package stall_pkg;

    localparam int unsigned STALL_DEPTH_DEF  = 3;
    localparam int unsigned STALL_DATA_W_DEF = 1;

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_RTZ
    } out_state_t;

endpackage

// File: rtl/stall_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
//   clk : sampling clock
//   rst : synchronous active-high reset, both flops clear to 0
//   d   : asynchronous input
//   q   : synchronized output, two edges behind d
module stall_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/stall_3_1_stage.sv
// Clocked stall element between two 4-phase req/ack pipeline stages.
// A DEPTH-entry FIFO absorbs back-pressure; upstream is stalled (ack held
// low) while the FIFO is full, downstream is served strictly in order.
// Optional macro STALL_3_1_SYNC_EN: route temp_req_in and temp_ack_in
// through 2-flop synchronizers; otherwise both are sampled directly.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   temp_req_in    : upstream request
//   temp_data_in   : upstream token, valid while temp_req_in=1
//   temp_ack_out   : acknowledge to upstream
//   temp_req_out   : request to downstream
//   temp_data_out  : token to downstream, stable while temp_req_out=1
//   temp_ack_in    : acknowledge from downstream
module stall_3_1_stage
    import stall_pkg::*;
#(
    parameter int unsigned DEPTH  = STALL_DEPTH_DEF,
    parameter int unsigned DATA_W = STALL_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              temp_req_in,
    input  logic [DATA_W-1:0] temp_data_in,
    output logic              temp_ack_out,
    output logic              temp_req_out,
    output logic [DATA_W-1:0] temp_data_out,
    input  logic              temp_ack_in
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic              req_s;
    logic              ack_s;
    in_state_t         in_state;
    in_state_t         in_state_nxt;
    out_state_t        out_state;
    out_state_t        out_state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              load;

    // Input conditioning
`ifdef STALL_3_1_SYNC_EN
    stall_sync2 u_sync_req (.clk(clk), .rst(rst), .d(temp_req_in), .q(req_s));
    stall_sync2 u_sync_ack (.clk(clk), .rst(rst), .d(temp_ack_in), .q(ack_s));
`else
    assign req_s = temp_req_in;
    assign ack_s = temp_ack_in;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy judged from the registered (pre-edge) count
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state  <= IN_IDLE;
            out_state <= OUT_IDLE;
        end else begin
            in_state  <= in_state_nxt;
            out_state <= out_state_nxt;
        end
    end

    // Upstream next state
    always_comb begin
        in_state_nxt = in_state;
        case (in_state)
            IN_IDLE: if (req_s && !full) in_state_nxt = IN_ACK;
            IN_ACK:  if (!req_s)         in_state_nxt = IN_IDLE;
            default:                     in_state_nxt = IN_IDLE;
        endcase
    end

    // Downstream next state; a stale ack in OUT_IDLE blocks a new request
    always_comb begin
        out_state_nxt = out_state;
        case (out_state)
            OUT_IDLE: if (!empty && !ack_s) out_state_nxt = OUT_REQ;
            OUT_REQ:  if (ack_s)            out_state_nxt = OUT_RTZ;
            OUT_RTZ:  if (!ack_s)           out_state_nxt = OUT_IDLE;
            default:                        out_state_nxt = OUT_IDLE;
        endcase
    end

    // FIFO strobes decoded from state and inputs
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        load = 1'b0;
        if (in_state == IN_IDLE && req_s && !full)       push = 1'b1;
        if (out_state == OUT_REQ && ack_s)               pop  = 1'b1;
        if (out_state == OUT_IDLE && !empty && !ack_s)   load = 1'b1;
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= temp_data_in;
    end

    // Pointers, occupancy and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            temp_ack_out  <= 1'b0;
            temp_req_out  <= 1'b0;
            temp_data_out <= '0;
        end else begin
            temp_ack_out <= (in_state_nxt == IN_ACK);
            temp_req_out <= (out_state_nxt == OUT_REQ);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (load) temp_data_out <= mem[rd_ptr];
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stall_3_1_stage.sv
// Directed self-checking bench for stall_3_1_stage (default build).
module tb_stall_3_1_stage;
    import stall_pkg::*;

    logic clk;
    logic rst;
    logic req_in;
    logic data_in;
    logic ack_out;
    logic req_out;
    logic data_out;
    logic ack_in;

    int pass_cnt;
    int total_cnt;

    stall_3_1_stage dut (
        .clk          (clk),
        .rst          (rst),
        .temp_req_in  (req_in),
        .temp_data_in (data_in),
        .temp_ack_out (ack_out),
        .temp_req_out (req_out),
        .temp_data_out(data_out),
        .temp_ack_in  (ack_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req_in = 1'b0; ack_in = 1'b0; data_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Downstream consumer: wait for req_out, check token, complete 4-phase
    task automatic consume(input logic exp, input string name);
        int n;
        n = 0;
        while (req_out !== 1'b1 && n < 20) begin tick(); n++; end
        total_cnt++;
        if (req_out !== 1'b1) $display("FAIL %s req_out timeout got=%b want=1", name, req_out);
        else if (data_out !== exp) $display("FAIL %s data_out got=%b want=%b", name, data_out, exp);
        else pass_cnt++;
        ack_in = 1'b1; tick();
        total_cnt++;
        if (req_out !== 1'b0) $display("FAIL %s req_out after ack got=%b want=0", name, req_out);
        else pass_cnt++;
        ack_in = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 1'b1; ack_in = 1'b1; data_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if ({ack_out, req_out, data_out} !== 3'b000)
                $display("FAIL reset edge%0d ack/req/data got=%b want=000", i, {ack_out, req_out, data_out});
            else pass_cnt++;
        end
    endtask

    task automatic test_held_stall();
        rst = 1'b1; tick();
        req_in = 1'b1; ack_in = 1'b1; data_in = 1'b0; rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++;
            if (ack_out !== 1'b1 || req_out !== 1'b0 || dut.count !== 2'd1)
                $display("FAIL held_stall edge%0d ack=%b req=%b count=%0d want ack=1 req=0 count=1",
                         i, ack_out, req_out, dut.count);
            else pass_cnt++;
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_in = 1'b1; data_in = 1'b1;
        tick();
        total_cnt++;
        if (ack_out !== 1'b1 || req_out !== 1'b0)
            $display("FAIL single edge1 ack=%b req=%b want ack=1 req=0", ack_out, req_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (req_out !== 1'b1 || data_out !== 1'b1)
            $display("FAIL single edge2 req=%b data=%b want req=1 data=1", req_out, data_out);
        else pass_cnt++;
        req_in = 1'b0; tick();
        total_cnt++;
        if (ack_out !== 1'b0) $display("FAIL single ack_rtz got=%b want=0", ack_out);
        else pass_cnt++;
        ack_in = 1'b1; tick();
        total_cnt++;
        if (req_out !== 1'b0 || dut.count !== 2'd0)
            $display("FAIL single pop req=%b count=%0d want req=0 count=0", req_out, dut.count);
        else pass_cnt++;
        ack_in = 1'b0; tick();
        total_cnt++;
        if (dut.out_state !== OUT_IDLE || req_out !== 1'b0)
            $display("FAIL single out_idle state=%0d req=%b want state=0 req=0", dut.out_state, req_out);
        else pass_cnt++;
    endtask

    task automatic test_fill_stall();
        logic toks [3];
        toks[0] = 1'b1; toks[1] = 1'b0; toks[2] = 1'b1;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            req_in = 1'b1; data_in = toks[i]; tick();
            total_cnt++;
            if (ack_out !== 1'b1) $display("FAIL fill push%0d ack got=%b want=1", i, ack_out);
            else pass_cnt++;
            req_in = 1'b0; tick();
        end
        total_cnt++;
        if (dut.count !== 2'd3 || req_out !== 1'b1 || data_out !== 1'b1)
            $display("FAIL fill full count=%0d req=%b data=%b want 3/1/1", dut.count, req_out, data_out);
        else pass_cnt++;
        req_in = 1'b1; data_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (ack_out !== 1'b0) $display("FAIL fill stall%0d ack got=%b want=0", i, ack_out);
            else pass_cnt++;
        end
        ack_in = 1'b1; tick();
        total_cnt++;
        if (ack_out !== 1'b0 || req_out !== 1'b0 || dut.count !== 2'd2)
            $display("FAIL fill pop_edge ack=%b req=%b count=%0d want 0/0/2", ack_out, req_out, dut.count);
        else pass_cnt++;
        ack_in = 1'b0; tick();
        total_cnt++;
        if (ack_out !== 1'b1 || dut.count !== 2'd3)
            $display("FAIL fill reuse ack=%b count=%0d want 1/3", ack_out, dut.count);
        else pass_cnt++;
        req_in = 1'b0;
        consume(1'b0, "fill_tok2");
        consume(1'b1, "fill_tok3");
        consume(1'b1, "fill_tok4");
        total_cnt++;
        if (dut.count !== 2'd0) $display("FAIL fill drained count=%0d want=0", dut.count);
        else pass_cnt++;
    endtask

    // Push two tokens with downstream idle; leaves OUT_REQ holding token a, count=2
    task automatic load_two(input logic a, input logic b);
        apply_reset();
        req_in = 1'b1; data_in = a; tick();
        req_in = 1'b0; tick();
        req_in = 1'b1; data_in = b; tick();
        req_in = 1'b0; tick();
    endtask

    task automatic test_push_pop();
        load_two(1'b0, 1'b1);
        total_cnt++;
        if (dut.count !== 2'd2 || req_out !== 1'b1 || data_out !== 1'b0)
            $display("FAIL pp setup count=%0d req=%b data=%b want 2/1/0", dut.count, req_out, data_out);
        else pass_cnt++;
        req_in = 1'b1; data_in = 1'b0; ack_in = 1'b1; tick();
        total_cnt++;
        if (dut.count !== 2'd2 || ack_out !== 1'b1 || req_out !== 1'b0)
            $display("FAIL pp same_edge count=%0d ack=%b req=%b want 2/1/0", dut.count, ack_out, req_out);
        else pass_cnt++;
        req_in = 1'b0; ack_in = 1'b0; tick();
        consume(1'b1, "pp_tok1");
        consume(1'b0, "pp_tok2");
        total_cnt++;
        if (dut.count !== 2'd0 || req_out !== 1'b0)
            $display("FAIL pp drained count=%0d req=%b want 0/0", dut.count, req_out);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        load_two(1'b1, 1'b0);
        total_cnt++;
        if (dut.out_state !== OUT_REQ || dut.count !== 2'd2)
            $display("FAIL midrst setup state=%0d count=%0d want 1/2", dut.out_state, dut.count);
        else pass_cnt++;
        rst = 1'b1; tick();
        total_cnt++;
        if (req_out !== 1'b0 || ack_out !== 1'b0 || data_out !== 1'b0 || dut.count !== 2'd0)
            $display("FAIL midrst clear req=%b ack=%b data=%b count=%0d want all 0",
                     req_out, ack_out, data_out, dut.count);
        else pass_cnt++;
        rst = 1'b0; req_in = 1'b1; data_in = 1'b1; tick();
        total_cnt++;
        if (ack_out !== 1'b1 || req_out !== 1'b0)
            $display("FAIL midrst edge1 ack=%b req=%b want 1/0", ack_out, req_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (req_out !== 1'b1 || data_out !== 1'b1)
            $display("FAIL midrst edge2 req=%b data=%b want 1/1", req_out, data_out);
        else pass_cnt++;
        req_in = 1'b0;
        consume(1'b1, "midrst_tok");
        total_cnt++;
        if (dut.count !== 2'd0) $display("FAIL midrst drained count=%0d want=0", dut.count);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b1; req_in = 1'b0; ack_in = 1'b0; data_in = 1'b0;
        test_reset();
        test_held_stall();
        test_single();
        test_fill_stall();
        test_push_pop();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
